// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants.
//   fetch_state_e : fetch FSM encoding
//   fetch_entry_t : {pc, instr} payload carried through the fetch queue
package riscv_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned PC_WIDTH    = 32;
  localparam logic [PC_WIDTH-1:0]    PC_STEP = 32'd4;
  localparam logic [INSTR_WIDTH-1:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_TRAP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} FIFO between the instruction memory and decode.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, data : write one entry
//   pop        : remove head (ignored when empty)
//   flush      : drop all entries; overrides push/pop
//   count      : current occupancy (0..2)
//   head       : oldest entry (undefined content when count == 0)
module fetch_queue
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic [1:0]   count_q;
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_pop_c;

  assign do_pop_c = pop && (count_q != 2'd0);
  assign count    = count_q;
  assign head     = mem[rd_ptr];

  // Storage and pointers; a push at full is only legal alongside a pop,
  // in which case it overwrites the slot being retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      count_q <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
    end else if (flush) begin
      count_q <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop_c) rd_ptr <= ~rd_ptr;
      count_q <= count_q + 2'(push) - 2'(do_pop_c);
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !do_pop_c && !flush && (count_q == 2'd2)))
    else $error("fetch_queue overflow");

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, synchronous imem request, 2-entry
// return buffer and valid/ready hand-off to decode, with branch redirect.
// Optional macro IFETCH_MISALIGN_TRAP_EN adds the sticky 'misalign' output
// and the S_TRAP state for redirect targets that are not word aligned.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   fetch_en             : allow new memory requests
//   imem_req/imem_addr   : word read request (combinational)
//   imem_rdata           : read data, one cycle after imem_req
//   instr_valid/ready    : decode handshake; instr/instr_pc = queue head
//   redirect/_target     : taken-branch pulse and byte target
//   misalign             : (macro only) sticky misaligned-target flag
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
`ifdef IFETCH_MISALIGN_TRAP_EN
  output logic                   misalign,
`endif
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_target
);

  fetch_state_e        state, state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic                epoch;
  logic                infl_valid;
  logic                infl_epoch;
  logic [PC_WIDTH-1:0] infl_pc;

  logic [1:0]   q_count;
  fetch_entry_t q_head;
  fetch_entry_t q_data;

  logic       pop_c, push_c, redirect_c, trap_c, credit_c, req_c;
  logic [1:0] used_c;

  assign instr_valid = (q_count != 2'd0);
  assign pop_c       = instr_valid && instr_ready;

  // Credits count this cycle's pop so a full-rate stream never stalls.
  assign used_c   = q_count - 2'(pop_c) + 2'(infl_valid);
  assign credit_c = (used_c < 2'd2);

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign redirect_c = redirect && (state != S_BOOT) && (state != S_TRAP);
  assign trap_c     = redirect_c && (redirect_target[1:0] != 2'b00);
`else
  logic unused_target_lsb;
  assign unused_target_lsb = ^redirect_target[1:0];
  assign redirect_c        = redirect && (state != S_BOOT);
  assign trap_c            = 1'b0;
`endif

  assign req_c     = (state == S_RUN) && credit_c && fetch_en && !redirect_c;
  assign imem_req  = req_c;
  assign imem_addr = pc[ADDR_WIDTH+1:2];

  // Returning word is kept only if no redirect happened since it was issued.
  assign push_c = infl_valid && (infl_epoch == epoch) && !redirect_c;
  assign q_data = {infl_pc, imem_rdata};

  fetch_queue u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .data  (q_data),
    .pop   (pop_c),
    .flush (redirect_c),
    .count (q_count),
    .head  (q_head)
  );

  assign instr    = q_head.instr;
  assign instr_pc = q_head.pc;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_RUN;
      S_RUN:   if (!credit_c || !fetch_en) state_nxt = S_HOLD;
      S_HOLD:  if (credit_c && fetch_en)   state_nxt = S_RUN;
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_BOOT;
    endcase
    if (redirect_c) state_nxt = trap_c ? S_TRAP : S_RUN;
  end

  // PC, epoch and the single in-flight read tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      epoch      <= 1'b0;
      infl_valid <= 1'b0;
      infl_epoch <= 1'b0;
      infl_pc    <= '0;
    end else if (redirect_c) begin
      pc         <= {redirect_target[PC_WIDTH-1:2], 2'b00};
      epoch      <= ~epoch;
      infl_valid <= 1'b0;
    end else begin
      infl_valid <= req_c;
      if (req_c) begin
        pc         <= pc + PC_STEP;
        infl_pc    <= pc;
        infl_epoch <= epoch;
      end
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  // Sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      misalign <= 1'b0;
    else if (trap_c) misalign <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle table for start-up and stall,
// scoreboard-checked redirect / fetch_en / misalign sequences, and a second
// instance with RESET_PC near the top of the address space for PC wrap.
module tb_instr_fetch;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, fetch_en, imem_req, instr_valid, instr_ready, redirect;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata, instr, instr_pc, redirect_target;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        misalign, misalign2;
`endif

  logic        rst2_n, fetch_en2, req2, valid2, ready2, redirect2;
  logic [7:0]  addr2;
  logic [31:0] rdata2, instr2, pc2, target2;

  instr_fetch #(.ADDR_WIDTH(8), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
`ifdef IFETCH_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .redirect(redirect), .redirect_target(redirect_target)
  );

  instr_fetch #(.ADDR_WIDTH(8), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst2_n), .fetch_en(fetch_en2),
    .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
    .instr_valid(valid2), .instr_ready(ready2),
    .instr(instr2), .instr_pc(pc2),
`ifdef IFETCH_MISALIGN_TRAP_EN
    .misalign(misalign2),
`endif
    .redirect(redirect2), .redirect_target(target2)
  );

  // Synchronous ROM, 1-cycle latency; garbage when not requested.
  logic [31:0] rom [256];
  always @(posedge clk) imem_rdata <= imem_req ? rom[imem_addr] : 32'hDEAD_BEEF;
  always @(posedge clk) rdata2     <= req2     ? rom[addr2]     : 32'hDEAD_BEEF;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard of expected {pc, instr} in delivery order.
  typedef struct packed { logic [31:0] pc; logic [31:0] word; } exp_t;
  exp_t sbq[$];
  logic sb_en = 1'b0;

  function automatic exp_t mk_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = rom[pc[9:2]];
    return e;
  endfunction

  task automatic sb_push_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sbq.push_back(mk_exp(start + 32'(4 * i)));
  endtask

  always @(negedge clk) begin
    if (sb_en && rst_n && instr_valid && instr_ready) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got pc %h expected no word", instr_pc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_pc", instr_pc, e.pc);
        check("sb_instr", instr, e.word);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse; returns in cycle 0 after release.
  task automatic do_reset();
    sb_en = 1'b0;
    sbq.delete();
    redirect = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(instr_valid), 32'd0);
    check("async_rst_req", 32'(imem_req), 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      next_cycle();
      n++;
    end
    check({name, "_drained"}, 32'(sbq.size()), 32'd0);
    instr_ready = 1'b0;
    sb_en = 1'b0;
  endtask

  typedef struct {
    logic        ready;
    logic        fen;
    logic        exp_valid;
    logic        exp_req;
    logic [7:0]  exp_addr;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[16];

  function automatic vec_t mk(input logic r, input logic f, input logic v,
                              input logic q, input logic [7:0] a, input logic [31:0] p);
    vec_t x;
    x.ready = r; x.fen = f; x.exp_valid = v; x.exp_req = q; x.exp_addr = a; x.exp_pc = p;
    return x;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wrap_pc [3];
    int n;
    for (int i = 0; i < 256; i++) rom[i] = NOP | (32'(i) << 20);
    rom[0] = 32'h0010_0093;
    rom[1] = 32'h0020_0113;
    rom[2] = 32'h0030_8193;
    rom[3] = 32'h0000_0000;

    // Cycle k = k-th cycle after reset release.
    vecs[0]  = mk(1, 1, 0, 0, 8'h00, 32'h00);
    vecs[1]  = mk(1, 1, 0, 1, 8'h00, 32'h00);
    vecs[2]  = mk(1, 1, 0, 1, 8'h01, 32'h00);
    vecs[3]  = mk(1, 1, 1, 1, 8'h02, 32'h00);
    vecs[4]  = mk(1, 1, 1, 1, 8'h03, 32'h04);
    vecs[5]  = mk(1, 1, 1, 1, 8'h04, 32'h08);
    vecs[6]  = mk(1, 1, 1, 1, 8'h05, 32'h0C);
    vecs[7]  = mk(0, 1, 1, 0, 8'h00, 32'h10);
    vecs[8]  = mk(0, 1, 1, 0, 8'h00, 32'h10);
    vecs[9]  = mk(0, 1, 1, 0, 8'h00, 32'h10);
    vecs[10] = mk(0, 1, 1, 0, 8'h00, 32'h10);
    vecs[11] = mk(0, 1, 1, 0, 8'h00, 32'h10);
    vecs[12] = mk(1, 1, 1, 0, 8'h00, 32'h10);
    vecs[13] = mk(1, 1, 1, 1, 8'h06, 32'h14);
    vecs[14] = mk(1, 1, 0, 1, 8'h07, 32'h00);
    vecs[15] = mk(1, 1, 1, 1, 8'h08, 32'h18);

    rst_n = 1'b0; rst2_n = 1'b0;
    fetch_en = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_target = '0;
    fetch_en2 = 1'b1; ready2 = 1'b1; redirect2 = 1'b0; target2 = '0;

    #2;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // Start-up, full-rate stream, 5-cycle stall, release.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      instr_ready = vecs[i].ready;
      fetch_en    = vecs[i].fen;
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req)
        check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_pc", i), instr_pc, vecs[i].exp_pc);
        check($sformatf("v%0d_instr", i), instr, rom[vecs[i].exp_pc[9:2]]);
      end
      next_cycle();
    end

    // Redirect with a word queued, a read returning and a pop, all in one cycle.
    do_reset();
    instr_ready = 1'b0;
    fetch_en = 1'b1;
    sb_push_run(32'h0, 1);
    sb_en = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    redirect = 1'b1;
    redirect_target = 32'h20;
    instr_ready = 1'b1;
    sb_push_run(32'h20, 6);
    @(negedge clk);
    check("redir_c3_valid", 32'(instr_valid), 32'd1);
    check("redir_c3_req", 32'(imem_req), 32'd0);
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    check("redir_c4_valid", 32'(instr_valid), 32'd0);
    check("redir_c4_req", 32'(imem_req), 32'd1);
    check("redir_c4_addr", 32'(imem_addr), 32'h08);
    next_cycle();
    @(negedge clk);
    check("redir_c5_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("redir_c6_valid", 32'(instr_valid), 32'd1);
    check("redir_c6_pc", instr_pc, 32'h20);
    drain("redir");

    // Redirect in boot is ignored; fetch_en low mid-stream drains, then resumes.
    do_reset();
    instr_ready = 1'b1;
    fetch_en = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h40;
    sb_push_run(32'h0, 12);
    sb_en = 1'b1;
    @(negedge clk);
    check("boot_req", 32'(imem_req), 32'd0);
    next_cycle();
    redirect = 1'b0;
    redirect_target = '0;
    @(negedge clk);
    check("boot_ignored_req", 32'(imem_req), 32'd1);
    check("boot_ignored_addr", 32'(imem_addr), 32'd0);
    next_cycle(); next_cycle(); next_cycle(); next_cycle();
    fetch_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("fen_off%0d_req", i), 32'(imem_req), 32'd0);
      next_cycle();
    end
    fetch_en = 1'b1;
    @(negedge clk);
    check("fen_drained_valid", 32'(instr_valid), 32'd0);
    n = 0;
    while (!imem_req && n < 10) begin
      next_cycle();
      n++;
    end
    check("fen_resume_req", 32'(imem_req), 32'd1);
    check("fen_resume_addr", 32'(imem_addr), 32'h04);
    drain("fen");

    // Misaligned redirect target.
    do_reset();
    instr_ready = 1'b1;
    fetch_en = 1'b1;
    sb_push_run(32'h0, 2);
    sb_en = 1'b1;
`ifdef IFETCH_MISALIGN_TRAP_EN
    @(negedge clk);
    check("mis_initial", 32'(misalign), 32'd0);
`endif
    next_cycle(); next_cycle(); next_cycle(); next_cycle();
    redirect = 1'b1;
    redirect_target = 32'h22;
`ifndef IFETCH_MISALIGN_TRAP_EN
    sb_push_run(32'h20, 4);
`endif
    next_cycle();
    redirect = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("trap%0d_misalign", i), 32'(misalign), 32'd1);
      check($sformatf("trap%0d_valid", i), 32'(instr_valid), 32'd0);
      check($sformatf("trap%0d_req", i), 32'(imem_req), 32'd0);
      next_cycle();
    end
    check("trap_sb_empty", 32'(sbq.size()), 32'd0);
    sb_en = 1'b0;
`else
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("mis_valid", 32'(instr_valid), 32'd1);
    check("mis_pc", instr_pc, 32'h20);
    drain("mis");
`endif

    // PC wrap from RESET_PC = FFFF_FFF8.
    wrap_pc[0] = 32'hFFFF_FFF8;
    wrap_pc[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'h0000_0000;
    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("wrap%0d_valid", k), 32'(valid2), (k >= 3) ? 32'd1 : 32'd0);
      if (k >= 3) begin
        check($sformatf("wrap%0d_pc", k), pc2, wrap_pc[k-3]);
        check($sformatf("wrap%0d_instr", k), instr2, rom[wrap_pc[k-3][9:2]]);
      end
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
